bram_arbiter: RTL and testbench
===============================

Name: bram_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-port word-addressed block RAM.
- Shares the RAM between the instruction-fetch port (I) and the load/store port (D).
- Issues at most one RAM access per cycle and routes the 1-cycle-latency read data back to the port that issued it.
- Converts byte/halfword stores (partial strobes) into a read-modify-write sequence, because the RAM only performs full-word writes.

Parameters:
- DATA_FIRST, 1, priority pointer value after reset: 1 = D wins the first conflict, 0 = I wins it.
- ENABLE_RMW, 1, 1 = partial strobes use read-modify-write; 0 = any nonzero strobe is written as a full word.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- i_req  in  1  instruction read request, held until granted
- i_addr  in  32  byte address; bits [1:0] ignored
- i_gnt  out  1  request accepted this cycle (combinational)
- i_rvalid  out  1  i_rdata valid
- i_rdata  out  32  read word
- d_req  in  1  data request, held until granted
- d_we  in  1  1 = store, 0 = load
- d_wstrb  in  4  byte enables for stores; bit k covers byte [8k+7:8k]
- d_addr  in  32  byte address; bits [1:0] ignored
- d_wdata  in  32  store data
- d_gnt  out  1  request accepted this cycle (combinational)
- d_rvalid  out  1  load data valid, or store complete
- d_rdata  out  32  load word
- ram_en  out  1  to RAM en
- ram_we  out  1  to RAM we
- ram_rst  out  1  to RAM rst; equals rst
- ram_addr  out  32  to RAM addr (full byte address)
- ram_di  out  32  to RAM di
- ram_dout  in  32  from RAM dout (registered, 1-cycle latency)

Behaviour:
- Interface: single clock clk; reset rst is synchronous and active-high.
- States: IDLE and MERGE.
- Reset values:
  - State = IDLE; priority pointer = DATA_FIRST.
  - i_gnt, d_gnt, i_rvalid, d_rvalid, ram_en, ram_we = 0.
  - Pipeline tag cleared; rdata outputs unconstrained.
- IDLE, no requests: ram_en = 0.
- IDLE, one request: grant it the same cycle. Grant drives ram_en = 1, ram_addr = the port address, all combinationally.
- IDLE, both requesting: grant the port selected by the priority pointer, then point the pointer at the other port (round-robin). A single uncontested grant also moves the pointer away from the granted port.
- Read grant in cycle N:
  - ram_we = 0.
  - The port's rvalid is 1 in cycle N+1; its rdata = ram_dout (passthrough).
  - A new grant is allowed in cycle N+1, so back-to-back reads sustain 1 access per cycle.
- Full store (d_wstrb = 4'b1111, or ENABLE_RMW = 0 with d_wstrb nonzero):
  - Cycle N: ram_we = 1, ram_di = d_wdata.
  - Cycle N+1: d_rvalid = 1; d_rdata is the old word (read-first) and is don't-care to the core.
- d_we = 1 with d_wstrb = 4'b0000: behaves as a load (ram_we = 0).
- Partial store (ENABLE_RMW = 1, strobe not 0000 or 1111):
  - Cycle N: ram_en = 1, ram_we = 0. Latch addr, wdata and wstrb. Go to MERGE.
  - Cycle N+1 (MERGE): no grants. ram_en = 1, ram_we = 1, ram_addr = latched address. ram_di takes each byte from latched wdata where the strobe is 1, else from ram_dout. Return to IDLE.
  - Cycle N+2: d_rvalid = 1.
  - Occupancy: 2 cycles. A new grant is allowed in cycle N+2.
- Only the granted port's rvalid asserts. The two rvalids are never 1 in the same cycle.
- Requesters must hold req, addr, data and strobe stable until gnt. Changing them before gnt is undefined.
- Reset mid-operation:
  - Reset asserted during MERGE: the merge write is suppressed (ram_we = 0 that cycle) and the state returns to IDLE.
  - rvalids due in the cycle after reset are suppressed.
- ram_rst follows rst combinationally. RAM dout is therefore 0 after reset.

Test Plan:
- Single I read of addr 0x0000_0010, word 0xDEADBEEF -> i_gnt in cycle N, i_rvalid in cycle N+1 with i_rdata = 0xDEADBEEF, ram_addr = 0x10.
- i_req and d_req both held for 4 cycles, DATA_FIRST = 1 -> grants alternate D, I, D, I; the rvalids alternate and never overlap.
- Full store of 0x12345678 to 0x20, then a load from 0x20 -> d_rvalid at N+1; the load returns 0x12345678.
- Word at 0x40 = 0xAABBCCDD, store with wstrb = 0010 and wdata = 0x0000EE00 -> 2 busy cycles with i_gnt = 0 in MERGE; a reread gives 0xAABBEEDD.
- Partial store with rst asserted in the MERGE cycle -> no RAM write; word at 0x40 unchanged; all outputs at their reset values in the next cycle.
- 8 back-to-back I reads from 0x0 to 0x1C -> 8 consecutive i_rvalid cycles with the correct words in order.

Source files
------------

// File: rtl/bram_arbiter.sv
// bram_arbiter: shares one single-port, word-addressed block RAM between the
// instruction-fetch port (I) and the load/store port (D). At most one RAM
// access is issued per cycle. Read data (1-cycle RAM latency) is passed straight
// through to the port that issued the access. Byte/halfword stores become a
// read-modify-write, because the RAM only performs full-word writes.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   i_req/i_addr                instruction read request (held until i_gnt)
//   i_gnt/i_rvalid/i_rdata      same-cycle grant, read data one cycle later
//   d_req/d_we/d_wstrb/d_addr/d_wdata  load/store request (held until d_gnt)
//   d_gnt/d_rvalid/d_rdata      same-cycle grant, completion / load data
//   ram_en/ram_we/ram_rst/ram_addr/ram_di/ram_dout  block RAM interface
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | accepting requests; grants are decided combinationally
// MERGE | writing back the merged word of a partial store; no grants
module bram_arbiter #(
  parameter bit DATA_FIRST = 1'b1,
  parameter bit ENABLE_RMW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_wstrb,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        ram_en,
  output logic        ram_we,
  output logic        ram_rst,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_di,
  input  logic [31:0] ram_dout
);

  typedef enum logic {IDLE = 1'b0, MERGE = 1'b1} state_t;

  state_t      state;
  logic        ptr_d;      // 1: D wins the next conflict, 0: I wins it
  logic        tag_i;
  logic        tag_d;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_strb;

  logic        idle;
  logic        merging;
  logic        d_sel;
  logic        d_store;
  logic        d_partial;
  logic [31:0] merge_word;

  // Reset gates every grant and the merge write, so a reset cycle never
  // touches the RAM contents.
  assign idle    = (state == IDLE)  && !rst;
  assign merging = (state == MERGE) && !rst;

  // A zero strobe is not a store at all; it behaves as a load.
  assign d_store   = d_we && (d_wstrb != 4'b0000);
  assign d_partial = ENABLE_RMW && d_store && (d_wstrb != 4'b1111);

  assign d_sel = d_req && (!i_req || ptr_d);
  assign d_gnt = idle && d_sel;
  assign i_gnt = idle && i_req && !d_sel;

  always_comb begin
    merge_word = ram_dout;
    for (int k = 0; k < 4; k++) begin
      if (lat_strb[k]) merge_word[8*k +: 8] = lat_wdata[8*k +: 8];
    end
  end

  assign ram_rst  = rst;
  assign ram_en   = i_gnt || d_gnt || merging;
  assign ram_we   = merging || (d_gnt && d_store && !d_partial);
  assign ram_addr = merging ? lat_addr : (d_gnt ? d_addr : i_addr);
  assign ram_di   = merging ? merge_word : d_wdata;

  // Read data is a passthrough of the registered RAM output.
  assign i_rdata  = ram_dout;
  assign d_rdata  = ram_dout;
  assign i_rvalid = tag_i;
  assign d_rvalid = tag_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr_d <= DATA_FIRST;
      tag_i <= 1'b0;
      tag_d <= 1'b0;
    end else begin
      tag_i <= i_gnt;
      // A partial store completes one cycle after its merge write.
      tag_d <= (d_gnt && !d_partial) || (state == MERGE);
      if (d_gnt) ptr_d <= 1'b0;
      else if (i_gnt) ptr_d <= 1'b1;
      case (state)
        IDLE: begin
          if (d_gnt && d_partial) begin
            state     <= MERGE;
            lat_addr  <= d_addr;
            lat_wdata <= d_wdata;
            lat_strb  <= d_wstrb;
          end
        end
        MERGE:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_arbiter.sv
module tb_bram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_wstrb;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        ram_en;
  logic        ram_we;
  logic        ram_rst;
  logic [31:0] ram_addr;
  logic [31:0] ram_di;
  logic [31:0] ram_dout;

  always #5 clk = ~clk;

  bram_arbiter #(.DATA_FIRST(1'b1), .ENABLE_RMW(1'b1)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_wstrb(d_wstrb), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_rst(ram_rst), .ram_addr(ram_addr),
    .ram_di(ram_di), .ram_dout(ram_dout)
  );

  function automatic logic [31:0] init_word(input int k);
    return 32'h5A000000 ^ (k * 32'h00010203);
  endfunction

  // Block RAM: read-first, registered output, dout cleared by its reset.
  logic [31:0] mem [0:255];
  logic        mem_load;
  always @(posedge clk) begin
    if (mem_load) begin
      for (int k = 0; k < 256; k++) mem[k] <= init_word(k);
    end else if (!ram_rst && ram_en && ram_we) begin
      mem[ram_addr[9:2]] <= ram_di;
    end
    if (ram_rst) ram_dout <= 32'h0;
    else if (ram_en) ram_dout <= mem[ram_addr[9:2]];
  end

  // Reference model: memory contents as the core sees them, updated at grant.
  logic [31:0] gmem [0:255];

  typedef struct {
    logic [31:0] data;
    bit          chk;
    int          due;
  } exp_t;

  exp_t        iq[$];
  exp_t        dq[$];
  bit          gnt_log[$];
  int          i_gcyc[$];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] last_i;
  logic [31:0] last_d;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever a port presents rvalid.
  always @(negedge clk) begin
    exp_t e;
    if (i_gnt) gnt_log.push_back(1'b0);
    if (d_gnt) gnt_log.push_back(1'b1);
    chk("gnt_overlap", {31'b0, i_gnt & d_gnt}, 32'h0);
    chk("rvalid_overlap", {31'b0, i_rvalid & d_rvalid}, 32'h0);
    if (i_rvalid) begin
      if (iq.size() == 0) chk("i_rvalid_unexpected", {31'b0, i_rvalid}, 32'h0);
      else begin
        e = iq.pop_front();
        chk("i_latency", cyc, e.due);
        if (e.chk) chk("i_rdata", i_rdata, e.data);
        last_i = i_rdata;
      end
    end
    if (d_rvalid) begin
      if (dq.size() == 0) chk("d_rvalid_unexpected", {31'b0, d_rvalid}, 32'h0);
      else begin
        e = dq.pop_front();
        chk("d_latency", cyc, e.due);
        if (e.chk) chk("d_rdata", d_rdata, e.data);
        last_d = d_rdata;
      end
    end
  end

  task automatic i_read(input logic [31:0] a);
    int   n;
    exp_t e;
    i_addr = a;
    i_req  = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!i_gnt && n < 100);
    if (!i_gnt) begin
      chk("i_gnt_timeout", {31'b0, i_gnt}, 32'h1);
    end else begin
      chk("i_ram_addr", ram_addr, a);
      chk("i_ram_we", {31'b0, ram_we}, 32'h0);
      e.data = gmem[a[9:2]];
      e.chk  = 1'b1;
      e.due  = cyc + 1;
      iq.push_back(e);
      i_gcyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    i_req = 1'b0;
  endtask

  task automatic d_op(input logic we, input logic [3:0] strb,
                      input logic [31:0] a, input logic [31:0] wd);
    int   n;
    exp_t e;
    bit   store;
    bit   partial;
    d_we    = we;
    d_wstrb = strb;
    d_addr  = a;
    d_wdata = wd;
    d_req   = 1'b1;
    store   = we && (strb != 4'h0);
    partial = store && (strb != 4'hF);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!d_gnt && n < 100);
    if (!d_gnt) begin
      chk("d_gnt_timeout", {31'b0, d_gnt}, 32'h1);
    end else begin
      chk("d_ram_addr", ram_addr, a);
      chk("d_ram_we", {31'b0, ram_we}, {31'b0, store && !partial});
      if (store && !partial) chk("d_ram_di", ram_di, wd);
      if (!store) begin
        e.data = gmem[a[9:2]];
        e.chk  = 1'b1;
        e.due  = cyc + 1;
      end else begin
        for (int k = 0; k < 4; k++)
          if (strb[k]) gmem[a[9:2]][8*k +: 8] = wd[8*k +: 8];
        e.data = 32'h0;
        e.chk  = 1'b0;
        e.due  = partial ? cyc + 2 : cyc + 1;
      end
      dq.push_back(e);
    end
    @(posedge clk);
    #1;
    d_req = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic [31:0] a;
    logic [3:0]  s;
    logic        w;
    int          g;

    rst = 1'b1;
    mem_load = 1'b1;
    i_req = 1'b1; i_addr = 32'h0;
    d_req = 1'b1; d_we = 1'b0; d_wstrb = 4'h0; d_addr = 32'h4; d_wdata = 32'h0;
    for (int k = 0; k < 256; k++) gmem[k] = init_word(k);
    @(posedge clk); #1;
    mem_load = 1'b0;

    // Requests during reset are not granted and nothing reaches the RAM.
    @(negedge clk);
    chk("rst_i_gnt", {31'b0, i_gnt}, 32'h0);
    chk("rst_d_gnt", {31'b0, d_gnt}, 32'h0);
    chk("rst_ram_en", {31'b0, ram_en}, 32'h0);
    chk("rst_ram_we", {31'b0, ram_we}, 32'h0);
    chk("rst_ram_rst", {31'b0, ram_rst}, 32'h1);
    @(posedge clk); #1;
    i_req = 1'b0; d_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_i_rvalid", {31'b0, i_rvalid}, 32'h0);
    chk("post_rst_d_rvalid", {31'b0, d_rvalid}, 32'h0);
    chk("post_rst_ram_en", {31'b0, ram_en}, 32'h0);
    chk("post_rst_ram_rst", {31'b0, ram_rst}, 32'h0);

    // Contention right after reset: D first, then alternating.
    @(posedge clk); #1;
    gnt_log.delete();
    fork
      begin i_read(32'h0); i_read(32'h4); end
      begin d_op(1'b0, 4'h0, 32'h8, 32'h0); d_op(1'b0, 4'h0, 32'hC, 32'h0); end
    join
    chk("arb_count", gnt_log.size(), 32'd4);
    if (gnt_log.size() == 4) begin
      chk("arb_0_is_d", {31'b0, gnt_log[0]}, 32'h1);
      chk("arb_1_is_i", {31'b0, gnt_log[1]}, 32'h0);
      chk("arb_2_is_d", {31'b0, gnt_log[2]}, 32'h1);
      chk("arb_3_is_i", {31'b0, gnt_log[3]}, 32'h0);
    end
    settle(2);

    d_op(1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
    i_read(32'h10);
    settle(2);
    chk("single_read_deadbeef", last_i, 32'hDEADBEEF);

    d_op(1'b1, 4'hF, 32'h20, 32'h12345678);
    d_op(1'b0, 4'h0, 32'h20, 32'h0);
    settle(2);
    chk("full_store_reload", last_d, 32'h12345678);

    // Partial store: I is held off during the merge cycle.
    d_op(1'b1, 4'hF, 32'h40, 32'hAABBCCDD);
    fork
      d_op(1'b1, 4'b0010, 32'h40, 32'h0000EE00);
      begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!d_gnt && n < 100);
        @(posedge clk); #1;
        i_addr = 32'h0;
        i_req  = 1'b1;
        @(negedge clk);
        chk("merge_i_gnt", {31'b0, i_gnt}, 32'h0);
        chk("merge_ram_we", {31'b0, ram_we}, 32'h1);
        chk("merge_ram_addr", ram_addr, 32'h40);
        chk("merge_ram_di", ram_di, 32'hAABBEEDD);
        i_read(32'h0);
      end
    join
    d_op(1'b0, 4'h0, 32'h40, 32'h0);
    settle(2);
    chk("partial_reread", last_d, 32'hAABBEEDD);

    // Reset during the merge cycle suppresses the write.
    d_we = 1'b1; d_wstrb = 4'b0100; d_addr = 32'h40; d_wdata = 32'h00990000;
    d_req = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!d_gnt && n < 100);
    chk("rmw_rst_gnt", {31'b0, d_gnt}, 32'h1);
    @(posedge clk); #1;
    d_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rmw_rst_ram_we", {31'b0, ram_we}, 32'h0);
    chk("rmw_rst_ram_en", {31'b0, ram_en}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rmw_rst_d_rvalid", {31'b0, d_rvalid}, 32'h0);
    chk("rmw_rst_i_rvalid", {31'b0, i_rvalid}, 32'h0);
    chk("rmw_rst_ram_en_after", {31'b0, ram_en}, 32'h0);
    chk("rmw_rst_ram_we_after", {31'b0, ram_we}, 32'h0);
    @(posedge clk); #1;
    d_op(1'b0, 4'h0, 32'h40, 32'h0);
    settle(2);
    chk("rmw_rst_word_unchanged", last_d, 32'hAABBEEDD);

    // Back-to-back instruction reads.
    i_gcyc.delete();
    for (int k = 0; k < 8; k++) i_read(k * 4);
    settle(2);
    chk("b2b_count", i_gcyc.size(), 32'd8);
    if (i_gcyc.size() == 8)
      for (int k = 1; k < 8; k++) chk("b2b_consecutive", i_gcyc[k] - i_gcyc[0], k);

    // Randomized traffic on both ports over a small shared window.
    fork
      begin
        for (int t = 0; t < 150; t++) begin
          g = $urandom_range(0, 2);
          repeat (g) begin @(posedge clk); #1; end
          a = $urandom_range(0, 31) * 4;
          i_read(a);
        end
      end
      begin
        for (int t = 0; t < 150; t++) begin
          logic [31:0] da;
          logic [31:0] dw;
          int          dg;
          dg = $urandom_range(0, 2);
          repeat (dg) begin @(posedge clk); #1; end
          da = $urandom_range(0, 31) * 4;
          dw = $urandom;
          w  = 1'($urandom_range(0, 1));
          s  = 4'($urandom_range(0, 15));
          d_op(w, s, da, dw);
        end
      end
    join
    settle(4);
    chk("i_queue_drained", iq.size(), 32'd0);
    chk("d_queue_drained", dq.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
